// File: rtl/seg_display_select_pkg.sv
// Shared encodings for the reaction-timer display path.
package seg_display_select_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } game_state_e;

  typedef enum logic {
    CEL_IDLE  = 1'b0,
    CEL_BLINK = 1'b1
  } cel_state_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg_display_select_sw_debounce.sv
// 2-FF synchroniser followed by a stability counter; dout follows din only
// after the synchronised value has differed from it for DEB_CYCLES cycles.
module sw_debounce #(
  parameter int unsigned DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             db_q, db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dout = db_q;

endmodule

// File: rtl/seg_display_select.sv
// Registered source selector for the seven-segment bank, with debounced
// high-score view switch and a timed new-high-score blink sequence.
module seg_display_select
  import seg_display_select_pkg::*;
#(
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned SEG_W         = 7,
  parameter int unsigned DEB_CYCLES    = 500000,
  parameter int unsigned BLINK_DIV     = 12500000,
  parameter int unsigned CELEB_TOGGLES = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              state,
  input  logic                    hs_sw,
  input  logic                    new_hs,
  input  logic [DIGITS*SEG_W-1:0] prompt_segs,
  input  logic [DIGITS*SEG_W-1:0] live_segs,
  input  logic [DIGITS*SEG_W-1:0] hs_segs,
  output logic [DIGITS*SEG_W-1:0] seg_out,
  output logic                    celebrating
);

  localparam int unsigned DIV_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int unsigned TOG_W = $clog2(CELEB_TOGGLES + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BLINK_DIV - 1);
  localparam logic [TOG_W-1:0] TOG_LAST = TOG_W'(CELEB_TOGGLES - 1);

  game_state_e st;
  logic        sw_db;

  cel_state_e                cel_q, cel_d;
  logic                      phase_on_q, phase_on_d;
  logic [DIV_W-1:0]          div_q, div_d;
  logic [TOG_W-1:0]          tog_q, tog_d;
  logic [DIGITS*SEG_W-1:0]   seg_q, seg_d;

  assign st = game_state_e'(state);

  sw_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_hs_debounce (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (hs_sw),
    .dout (sw_db)
  );

  // Leaving DONE cancels outright; new_hs in DONE (re)starts from phase ON.
  always_comb begin
    cel_d      = cel_q;
    phase_on_d = phase_on_q;
    div_d      = div_q;
    tog_d      = tog_q;
    if (st != ST_DONE) begin
      cel_d      = CEL_IDLE;
      phase_on_d = 1'b1;
      div_d      = '0;
      tog_d      = '0;
    end else if (new_hs) begin
      cel_d      = CEL_BLINK;
      phase_on_d = 1'b1;
      div_d      = '0;
      tog_d      = '0;
    end else if (cel_q == CEL_BLINK) begin
      if (div_q == DIV_LAST) begin
        div_d      = '0;
        phase_on_d = ~phase_on_q;
        tog_d      = tog_q + 1'b1;
        if (tog_q == TOG_LAST) begin
          cel_d = CEL_IDLE;
        end
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  always_comb begin
    seg_d = '1;
    if (sw_db) begin
      seg_d = hs_segs;
    end else begin
      case (st)
        ST_IDLE: seg_d = prompt_segs;
        ST_WAIT: seg_d = '1;
        ST_RUN:  seg_d = live_segs;
        ST_DONE: seg_d = (cel_q == CEL_BLINK && !phase_on_q) ? '1 : live_segs;
        default: seg_d = '1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cel_q      <= CEL_IDLE;
      phase_on_q <= 1'b1;
      div_q      <= '0;
      tog_q      <= '0;
      seg_q      <= '1;
    end else begin
      cel_q      <= cel_d;
      phase_on_q <= phase_on_d;
      div_q      <= div_d;
      tog_q      <= tog_d;
      seg_q      <= seg_d;
    end
  end

  assign seg_out     = seg_q;
  assign celebrating = (cel_q == CEL_BLINK);

endmodule

// File: tb/tb_seg_display_select.sv
// Directed bench for seg_display_select with small debounce/blink constants.
module tb_seg_display_select;

  localparam int unsigned DIGITS = 2;
  localparam int unsigned SEG_W  = 7;
  localparam int unsigned W      = DIGITS * SEG_W;

  localparam logic [W-1:0] BLANK  = 14'h3FFF;
  localparam logic [W-1:0] PROMPT = 14'h0123;
  localparam logic [W-1:0] LIVE_A = 14'h1555;
  localparam logic [W-1:0] LIVE_B = 14'h0AAA;
  localparam logic [W-1:0] HS     = 14'h2222;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   state;
  logic         hs_sw;
  logic         new_hs;
  logic [W-1:0] prompt_segs, live_segs, hs_segs;
  logic [W-1:0] seg_out;
  logic         celebrating;

  int unsigned errors = 0;
  int unsigned checks = 0;

  seg_display_select #(
    .DIGITS       (DIGITS),
    .SEG_W        (SEG_W),
    .DEB_CYCLES   (3),
    .BLINK_DIV    (4),
    .CELEB_TOGGLES(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .state      (state),
    .hs_sw      (hs_sw),
    .new_hs     (new_hs),
    .prompt_segs(prompt_segs),
    .live_segs  (live_segs),
    .hs_segs    (hs_segs),
    .seg_out    (seg_out),
    .celebrating(celebrating)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // j = edges after the new_hs sampling edge; 4 ON, 4 OFF, 4 ON, 4 OFF, then ON.
  function automatic logic [W-1:0] blink_exp(input int j);
    if (j >= 1 && j <= 16 && (((j - 1) / 4) % 2 == 1)) return BLANK;
    return LIVE_B;
  endfunction

  task automatic pulse_new_hs();
    new_hs = 1'b1;
    tick();
    new_hs = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; state = 2'd0; hs_sw = 1'b0; new_hs = 1'b0;
    prompt_segs = PROMPT; live_segs = LIVE_A; hs_segs = HS;

    // Reset and plain selection
    #2 rst_n = 1'b0;
    #1 check("reset_seg", 32'(seg_out), 32'(BLANK));
    check("reset_cel", 32'(celebrating), 32'd0);
    tick(); tick();
    check("reset_hold_seg", 32'(seg_out), 32'(BLANK));
    rst_n = 1'b1;
    tick();
    check("sel_prompt", 32'(seg_out), 32'(PROMPT));
    state = 2'd1;
    tick();
    check("sel_wait", 32'(seg_out), 32'(BLANK));
    state = 2'd2;
    tick();
    check("sel_run", 32'(seg_out), 32'(LIVE_A));

    // Short glitch must not reach the debounced level
    hs_sw = 1'b1;
    tick(); tick();
    hs_sw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("glitch_ignored", 32'(seg_out), 32'(LIVE_A));
    end

    // Held switch: high-score view after 2+3+1 edges, and back again
    hs_sw = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check("deb_rise", 32'(seg_out), (i == 6) ? 32'(HS) : 32'(LIVE_A));
    end
    hs_sw = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check("deb_fall", 32'(seg_out), (i == 6) ? 32'(LIVE_A) : 32'(HS));
    end

    // Full celebration
    state = 2'd3; live_segs = LIVE_B;
    new_hs = 1'b1;
    state = 2'd1;  // new_hs outside DONE is ignored
    tick();
    new_hs = 1'b0;
    check("ignored_new_hs", 32'(celebrating), 32'd0);
    state = 2'd3;
    tick();
    pulse_new_hs();
    check("cel_start", 32'(celebrating), 32'd1);
    for (int j = 1; j <= 20; j++) begin
      tick();
      check("cel_seg", 32'(seg_out), 32'(blink_exp(j)));
      check("cel_flag", 32'(celebrating), (j < 16) ? 32'd1 : 32'd0);
    end

    // Restart on a second pulse at edge 6
    pulse_new_hs();
    for (int j = 1; j <= 5; j++) tick();
    pulse_new_hs();
    check("restart_off_phase", 32'(seg_out), 32'(BLANK));
    for (int j = 1; j <= 18; j++) begin
      tick();
      check("restart_seg", 32'(seg_out), 32'(blink_exp(j)));
      check("restart_flag", 32'(celebrating), (j < 16) ? 32'd1 : 32'd0);
    end

    // Cancel by leaving DONE
    pulse_new_hs();
    for (int j = 1; j <= 4; j++) tick();
    check("cancel_pre", 32'(celebrating), 32'd1);
    state = 2'd0;
    tick();
    check("cancel_cel", 32'(celebrating), 32'd0);
    check("cancel_seg", 32'(seg_out), 32'(PROMPT));
    state = 2'd3;
    for (int j = 1; j <= 10; j++) begin
      tick();
      check("cancel_no_blink", 32'(seg_out), 32'(LIVE_B));
    end

    // Switch overrides the blink, which keeps running underneath
    hs_sw = 1'b1;
    for (int j = 1; j <= 8; j++) tick();
    check("ovr_hs", 32'(seg_out), 32'(HS));
    pulse_new_hs();
    for (int j = 1; j <= 20; j++) begin
      tick();
      check("ovr_seg", 32'(seg_out), 32'(HS));
      check("ovr_flag", 32'(celebrating), (j < 16) ? 32'd1 : 32'd0);
    end
    hs_sw = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check("ovr_release", 32'(seg_out), (i >= 6) ? 32'(LIVE_B) : 32'(HS));
    end

    // Asynchronous reset during the OFF phase
    pulse_new_hs();
    for (int j = 1; j <= 5; j++) tick();
    check("areset_pre", 32'(seg_out), 32'(BLANK));
    #2 rst_n = 1'b0;
    #1 check("areset_seg", 32'(seg_out), 32'(BLANK));
    check("areset_cel", 32'(celebrating), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      tick();
      check("post_reset_seg", 32'(seg_out), 32'(LIVE_B));
      check("post_reset_cel", 32'(celebrating), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_display_select.md
Name: seg_display_select

Overview:
Registered, parametrised source selector for the reaction-timer seven-segment bank. Drives DIGITS digits from three sources: the prompt pattern, the live/result timer and the stored high score. The choice depends on game state and a debounced high-score view switch. Adds behaviour a plain combinational selector lacks: switch synchronisation and debounce, and a timed "new high score" blink sequence in the result state. Sits between the timer/high-score logic and the HEX display pins.

Parameters:
DIGITS, 4, number of seven-segment digits driven
SEG_W, 7, segments per digit (active-low, 1 = segment off)
DEB_CYCLES, 500000, consecutive stable synchronised cycles required to accept a switch change (>=1)
BLINK_DIV, 12500000, cycles per blink half-period (>=1)
CELEB_TOGGLES, 6, number of blink half-periods in a celebration (even, >=2)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
state  in  2  game state: 0 IDLE, 1 WAIT, 2 RUN, 3 DONE
hs_sw  in  1  raw high-score view switch, asynchronous to clk
new_hs  in  1  single-cycle pulse: result just became the new high score
prompt_segs  in  DIGITS*SEG_W  prompt pattern, digit 0 in LSBs
live_segs  in  DIGITS*SEG_W  timer/result pattern
hs_segs  in  DIGITS*SEG_W  stored high-score pattern
seg_out  out  DIGITS*SEG_W  registered display drive
celebrating  out  1  high while the blink sequence is active

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - seg_out all ones (blank); celebrating 0.
  - Sync flops, debounced switch and counters all 0; blink phase ON.
- Switch path:
  - 2-FF synchroniser on hs_sw.
  - Debounced level sw_db takes the synchronised value once that value has differed from sw_db for DEB_CYCLES consecutive cycles.
  - The debounce counter clears whenever the synchronised value equals sw_db.
  - Glitches shorter than DEB_CYCLES never change sw_db.
- Celebration FSM, states CEL_IDLE and CEL_BLINK:
  - CEL_IDLE -> CEL_BLINK when new_hs=1 and state=3. Entry loads phase=ON, div counter=0, toggle counter=0.
  - In CEL_BLINK:
    - The div counter counts 0..BLINK_DIV-1.
    - On the terminal count, phase inverts and the toggle counter increments.
    - When the toggle counter reaches CELEB_TOGGLES, go to CEL_IDLE. Phase is then ON again, because CELEB_TOGGLES is even.
  - new_hs=1 during CEL_BLINK restarts the sequence (counters reload).
  - state != 3 in any cycle forces CEL_IDLE immediately, cancelling the sequence.
  - new_hs while state != 3 is ignored.
  - celebrating = (FSM in CEL_BLINK), registered.
- Source selection, evaluated each cycle; seg_out is updated at the next clk edge (1-cycle latency from state/segment inputs). Priority order:
  1. sw_db=1 -> hs_segs. The celebration keeps running underneath.
  2. state=0 -> prompt_segs.
  3. state=1 -> all ones.
  4. state=2 -> live_segs.
  5. state=3 -> live_segs if the celebration is not blinking or phase=ON; all ones if CEL_BLINK and phase=OFF.
- Width rules:
  - All counters are sized with $clog2 of their limit plus 1 where needed.
  - No counter wraps: the div counter resets on its terminal count, and the toggle counter stops at CELEB_TOGGLES.
- Reset mid-operation (debouncing or blinking) returns everything to the reset values on the same clock-independent assertion.

Decomposition:
- Shared package / header:
  - State encodings ST_IDLE=0, ST_WAIT=1, ST_RUN=2, ST_DONE=3.
  - SEG_BLANK constant (7'b1111111).
  - CEL_IDLE/CEL_BLINK encodings.
- One sub-module is natural: sw_debounce (2-FF sync plus DEB_CYCLES stability counter, parameter DEB_CYCLES, ports clk, rst_n, din, dout). It is reusable for the game's start and stop buttons.

Test Plan:
All scenarios use DIGITS=2, DEB_CYCLES=3, BLINK_DIV=4, CELEB_TOGGLES=4.
- Reset/select: assert rst_n=0 -> seg_out=14'h3FFF. Release with state=0, prompt_segs=14'h0123 -> seg_out=14'h0123 one edge after release. Step state 1/2 -> 14'h3FFF / live_segs, each one edge after the change.
- Debounce: pulse hs_sw high for 2 cycles -> seg_out never equals hs_segs. Hold hs_sw high -> seg_out=hs_segs exactly 2+3+1 edges after the rise. Release -> previous source returns after the same delay.
- Celebration: state=3, live_segs=14'h0AAA, one-cycle new_hs -> seg_out 0AAA for 4 cycles, 3FFF for 4, 0AAA for 4, 3FFF for 4, then steady 0AAA. celebrating high for exactly 16 cycles.
- Restart and cancel:
  - A second new_hs at cycle 6 -> pattern restarts at ON, celebrating stays high for 16 cycles from the second pulse.
  - state->0 at cycle 5 -> celebrating=0 and seg_out=prompt_segs on the next edge.
- Switch overrides blink: sw_db=1 during celebration -> seg_out=hs_segs throughout. Release at the end -> steady live_segs, with no blank phase if the sequence has finished.
- Async reset mid-blink: drop rst_n during phase OFF -> seg_out=3FFF and celebrating=0 immediately, without waiting for a clock edge. After release, no blinking without a new new_hs.
